// File: rtl/iter_div_unit.sv
// Purpose: multi-cycle radix-2 restoring divider for the EX stage (RV32M DIV/DIVU/REM/REMU).
//          Produces one quotient bit per cycle, MSB first. divider_busy stalls the pipeline
//          until the cycle in which quotient/remainder become valid.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ID_EX_vld        EX holds a valid instruction
//   ID_EX_alu_func   ALU function; ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU start the unit
//   opa, opb         dividend, divisor (sampled only in the start cycle)
//   pipe_stall       ID/EX held for another reason; keeps the unit in DONE
//   quotient         registered quotient
//   remainder        registered remainder
//   divider_busy     combinational stall request
module iter_div_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [4:0]  ALU_DIV  = 5'h0C,
    parameter logic [4:0]  ALU_DIVU = 5'h0D,
    parameter logic [4:0]  ALU_REM  = 5'h0E,
    parameter logic [4:0]  ALU_REMU = 5'h0F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_vld,
    input  logic [4:0]       ID_EX_alu_func,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             pipe_stall,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divider_busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient bits shift in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;

    logic               is_div, is_sgn, start, a_neg, b_neg, qbit;
    logic [WIDTH:0]     r_wide, diff;
    logic [WIDTH-1:0]   r_next, q_next;

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

    // Next-state, datapath step and busy request
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        rem_d        = rem_q;
        neg_q_d      = neg_q_q;
        neg_r_d      = neg_r_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        divider_busy = 1'b0;

        is_div = (ID_EX_alu_func == ALU_DIV) || (ID_EX_alu_func == ALU_DIVU) ||
                 (ID_EX_alu_func == ALU_REM) || (ID_EX_alu_func == ALU_REMU);
        is_sgn = (ID_EX_alu_func == ALU_DIV) || (ID_EX_alu_func == ALU_REM);
        start  = ID_EX_vld && is_div && (state_q == S_IDLE);
        a_neg  = is_sgn && opa[WIDTH-1];
        b_neg  = is_sgn && opb[WIDTH-1];

        // Shifted remainder keeps its top bit so a divisor near 2^WIDTH compares correctly
        r_wide = {rem_q, dvd_q[WIDTH-1]};
        diff   = r_wide - {1'b0, dvs_q};
        qbit   = ~diff[WIDTH];
        r_next = qbit ? diff[WIDTH-1:0] : r_wide[WIDTH-1:0];
        q_next = {dvd_q[WIDTH-2:0], qbit};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    divider_busy = 1'b1;
                    if (opb == '0) begin
                        quotient_d  = '1;
                        remainder_d = opa;
                        state_d     = S_DONE;
                    end else if (is_sgn && (opa == MIN_NEG) && (opb == '1)) begin
                        quotient_d  = opa;
                        remainder_d = '0;
                        state_d     = S_DONE;
                    end else begin
                        dvd_d   = a_neg ? (~opa + WIDTH'(1)) : opa;
                        dvs_d   = b_neg ? (~opb + WIDTH'(1)) : opb;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        rem_d   = '0;
                        count_d = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                divider_busy = 1'b1;
                dvd_d        = q_next;
                rem_d        = r_next;
                count_d      = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH-1)) begin
                    quotient_d  = neg_q_q ? (~q_next + WIDTH'(1)) : q_next;
                    remainder_d = neg_r_q ? (~r_next + WIDTH'(1)) : r_next;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // Held in DONE while the pipe is stalled so the same op is not restarted
                if (!pipe_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            divider_busy = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed testbench for iter_div_unit (WIDTH=32).
module tb_iter_div_unit;

    localparam logic [4:0] ALU_ADD  = 5'h00;
    localparam logic [4:0] ALU_DIV  = 5'h0C;
    localparam logic [4:0] ALU_DIVU = 5'h0D;
    localparam logic [4:0] ALU_REM  = 5'h0E;
    localparam logic [4:0] ALU_REMU = 5'h0F;
    localparam int NORM_CYC = 33;   // busy cycles for a normal op: start + 32 CALC

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_EX_vld;
    logic [4:0]  ID_EX_alu_func;
    logic [31:0] opa, opb;
    logic        pipe_stall;
    logic [31:0] quotient, remainder;
    logic        divider_busy;

    int errors = 0;
    int checks = 0;

    iter_div_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_EX_vld      (ID_EX_vld),
        .ID_EX_alu_func (ID_EX_alu_func),
        .opa            (opa),
        .opb            (opb),
        .pipe_stall     (pipe_stall),
        .quotient       (quotient),
        .remainder      (remainder),
        .divider_busy   (divider_busy)
    );

    always #5 clk = ~clk;

    // Presents an op from IDLE and returns when busy drops (bounded); leaves the op presented.
    task automatic run_div(input logic [4:0] func, input logic [31:0] a, input logic [31:0] b,
                           input bit scramble, output int cyc, output logic [31:0] q,
                           output logic [31:0] r);
        @(negedge clk);
        ID_EX_vld = 1'b1; ID_EX_alu_func = func; opa = a; opb = b;
        #1;
        cyc = 0;
        while (divider_busy && cyc < 60) begin
            cyc++;
            @(negedge clk);
            if (scramble && cyc == 2) begin
                opa = $urandom; opb = $urandom; ID_EX_alu_func = ALU_ADD;
            end
            #1;
        end
        q = quotient; r = remainder;
    endtask

    task automatic test_reset();
        rst = 1'b1; ID_EX_vld = 1'b1; ID_EX_alu_func = ALU_DIVU;
        opa = 32'd10; opb = 32'd2; pipe_stall = 1'b0;
        @(negedge clk); #1;
        checks++; if (divider_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", divider_busy); end
        @(negedge clk);
        ID_EX_vld = 1'b0; rst = 1'b0;
        #1;
        checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++; $display("FAIL rst_out got q=%h r=%h exp 0/0", quotient, remainder);
        end
    endtask

    task automatic test_idle_ignore();
        @(negedge clk);
        ID_EX_vld = 1'b1; ID_EX_alu_func = ALU_ADD; #1;
        checks++; if (divider_busy !== 1'b0) begin errors++; $display("FAIL nondiv_busy got=%b exp=0", divider_busy); end
        @(negedge clk);
        ID_EX_vld = 1'b0; ID_EX_alu_func = ALU_DIVU; #1;
        checks++; if (divider_busy !== 1'b0) begin errors++; $display("FAIL novld_busy got=%b exp=0", divider_busy); end
        @(negedge clk); #1;
        checks++; if (divider_busy !== 1'b0) begin errors++; $display("FAIL novld_busy2 got=%b exp=0", divider_busy); end
    endtask

    task automatic test_normal();
        int cyc; logic [31:0] q, r;
        run_div(ALU_DIVU, 32'd100, 32'd7, 1'b1, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'd14 || r !== 32'd2) begin
            errors++; $display("FAIL divu_100_7 got cyc=%0d q=%h r=%h exp cyc=33 q=e r=2", cyc, q, r);
        end
        run_div(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_m7_2 got cyc=%0d q=%h r=%h exp cyc=33 q=fffffffd r=ffffffff", cyc, q, r);
        end
        run_div(ALU_REM, 32'd7, 32'hFFFF_FFFE, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'hFFFF_FFFD || r !== 32'd1) begin
            errors++; $display("FAIL rem_7_m2 got cyc=%0d q=%h r=%h exp cyc=33 q=fffffffd r=1", cyc, q, r);
        end
        run_div(ALU_REMU, 32'd1000, 32'd7, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'd142 || r !== 32'd6) begin
            errors++; $display("FAIL remu_1000_7 got cyc=%0d q=%h r=%h exp cyc=33 q=8e r=6", cyc, q, r);
        end
    endtask

    task automatic test_boundary();
        int cyc; logic [31:0] q, r;
        run_div(ALU_DIVU, 32'h0000_1234, 32'd0, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== 1 || q !== 32'hFFFF_FFFF || r !== 32'h0000_1234) begin
            errors++; $display("FAIL divu_by0 got cyc=%0d q=%h r=%h exp cyc=1 q=ffffffff r=1234", cyc, q, r);
        end
        run_div(ALU_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== 1 || q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF9) begin
            errors++; $display("FAIL div_by0 got cyc=%0d q=%h r=%h exp cyc=1 q=ffffffff r=fffffff9", cyc, q, r);
        end
        run_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== 1 || q !== 32'h8000_0000 || r !== 32'd0) begin
            errors++; $display("FAIL div_ovf got cyc=%0d q=%h r=%h exp cyc=1 q=80000000 r=0", cyc, q, r);
        end
        run_div(ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'd0 || r !== 32'h8000_0000) begin
            errors++; $display("FAIL divu_nonovf got cyc=%0d q=%h r=%h exp cyc=33 q=0 r=80000000", cyc, q, r);
        end
        run_div(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'hFFFF_FFFF || r !== 32'd0) begin
            errors++; $display("FAIL divu_max_1 got cyc=%0d q=%h r=%h exp cyc=33 q=ffffffff r=0", cyc, q, r);
        end
        run_div(ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'd1 || r !== 32'd1) begin
            errors++; $display("FAIL divu_max_maxm1 got cyc=%0d q=%h r=%h exp cyc=33 q=1 r=1", cyc, q, r);
        end
    endtask

    task automatic test_mid_reset();
        int cyc; logic [31:0] q, r;
        @(negedge clk);
        ID_EX_vld = 1'b1; ID_EX_alu_func = ALU_DIVU; opa = 32'd1000; opb = 32'd3;
        repeat (11) @(negedge clk);   // now in CALC cycle 10
        ID_EX_vld = 1'b0; rst = 1'b1; #1;
        checks++; if (divider_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", divider_busy); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (divider_busy !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++; $display("FAIL midrst_after got busy=%b q=%h r=%h exp 0/0/0", divider_busy, quotient, remainder);
        end
        run_div(ALU_DIVU, 32'd9, 32'd3, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'd3 || r !== 32'd0) begin
            errors++; $display("FAIL post_rst_9_3 got cyc=%0d q=%h r=%h exp cyc=33 q=3 r=0", cyc, q, r);
        end
    endtask

    task automatic test_stall_back_to_back();
        int cyc; logic [31:0] q, r;
        run_div(ALU_DIVU, 32'd50, 32'd5, 1'b0, cyc, q, r);
        pipe_stall = 1'b1;   // op stays presented
        checks++; if (cyc !== NORM_CYC || q !== 32'd10 || r !== 32'd0) begin
            errors++; $display("FAIL stall_op got cyc=%0d q=%h r=%h exp cyc=33 q=a r=0", cyc, q, r);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (divider_busy !== 1'b0 || quotient !== 32'd10 || remainder !== 32'd0) begin
                errors++; $display("FAIL stall_hold%0d got busy=%b q=%h r=%h exp 0/a/0", i, divider_busy, quotient, remainder);
            end
        end
        pipe_stall = 1'b0;
        run_div(ALU_DIVU, 32'd1000, 32'd7, 1'b0, cyc, q, r);
        checks++; if (cyc !== NORM_CYC || q !== 32'd142 || r !== 32'd6) begin
            errors++; $display("FAIL b2b_1 got cyc=%0d q=%h r=%h exp cyc=33 q=8e r=6", cyc, q, r);
        end
        run_div(ALU_DIVU, 32'hDEAD_BEEF, 32'h10, 1'b0, cyc, q, r);
        ID_EX_vld = 1'b0;
        checks++; if (cyc !== NORM_CYC || q !== 32'h0DEA_DBEE || r !== 32'hF) begin
            errors++; $display("FAIL b2b_2 got cyc=%0d q=%h r=%h exp cyc=33 q=0deadbee r=f", cyc, q, r);
        end
        @(negedge clk); #1;
        checks++; if (divider_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp=0", divider_busy); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_normal();
        test_boundary();
        test_mid_reset();
        test_stall_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
